// File: rtl/div_issue_ctrl.sv
// Issue/sequencing controller between execute and the iterative RV32M divider.
// Optional DIV_RESULT_CACHE_EN adds a one-entry cache of the last divider result.
module div_issue_ctrl #(
  parameter int TAG_W       = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [2:0]       in_funct3,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             div_valid,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  output logic [2:0]       div_funct3,
  input  logic [31:0]      div_res,
  input  logic             div_done,
  output logic             timeout_err,
  output logic [2:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and payload is held while valid
  // is high and ready is low.

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_DRAIN  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              special_hit;
  logic [31:0]       special_res;
  logic              cache_hit;
  logic              cnt_last;
  logic              timeout_hit;
  logic              wait_done;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_RESP);
  assign div_valid = (state == S_LAUNCH);
  assign state_dbg = state;

  assign accept    = (state == S_IDLE) && in_valid && !flush;
  assign cnt_last  = (cnt >= CNT_W'(TIMEOUT_CYC - 1));
  assign wait_done = (state == S_WAIT) && !flush && div_done;

  // Divide-by-zero and signed overflow are resolved without the divider.
  always_comb begin
    special_hit = 1'b0;
    special_res = 32'hFFFF_FFFF;
    if (in_b == 32'd0) begin
      special_hit = 1'b1;
      special_res = in_funct3[1] ? in_a : 32'hFFFF_FFFF;
    end else if (!in_funct3[0] && in_a == 32'h8000_0000 && in_b == 32'hFFFF_FFFF) begin
      special_hit = 1'b1;
      special_res = in_funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

`ifdef DIV_RESULT_CACHE_EN
  logic        cache_valid;
  logic [31:0] cache_a;
  logic [31:0] cache_b;
  logic [2:0]  cache_f3;
  logic [31:0] cache_res;

  assign cache_hit = cache_valid && (cache_a == in_a) && (cache_b == in_b) &&
                     (cache_f3 == in_funct3);

  // Only results completed in WAIT are kept; drained results are discarded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cache_valid <= 1'b0;
      cache_a     <= 32'd0;
      cache_b     <= 32'd0;
      cache_f3    <= 3'd0;
      cache_res   <= 32'd0;
    end else if (wait_done) begin
      cache_valid <= 1'b1;
      cache_a     <= div_a;
      cache_b     <= div_b;
      cache_f3    <= div_funct3;
      cache_res   <= div_res;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_next = (special_hit || cache_hit) ? S_RESP : S_LAUNCH;
      end
      S_LAUNCH: begin
        state_next = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          state_next = S_DRAIN;
        end else if (div_done) begin
          state_next = S_RESP;
        end else if (cnt_last) begin
          state_next  = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_DRAIN: begin
        // The divider cannot be aborted; wait it out and drop its result.
        if (div_done) begin
          state_next = S_IDLE;
        end else if (cnt_last) begin
          state_next  = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_RESP: begin
        if (flush || out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      timeout_err <= 1'b0;
      div_a       <= 32'd0;
      div_b       <= 32'd0;
      div_funct3  <= 3'd0;
      out_res     <= 32'd0;
      out_tag     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        div_a      <= in_a;
        div_b      <= in_b;
        div_funct3 <= in_funct3;
        out_tag    <= in_tag;
        if (special_hit) begin
          out_res <= special_res;
        end
`ifdef DIV_RESULT_CACHE_EN
        else if (cache_hit) begin
          out_res <= cache_res;
        end
`endif
      end
      if (state == S_LAUNCH) begin
        cnt <= '0;
      end else if (state == S_WAIT || state == S_DRAIN) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (wait_done) begin
        out_res <= div_res;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule
